// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings for the 6502 interrupt/BRK/reset entry sequencer:
// sequence states, source codes, push selects and default vectors.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_PCH  = 3'd2,
        S_PCL  = 3'd3,
        S_P    = 3'd4,
        S_VL   = 3'd5,
        S_VH   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'b00,
        SRC_RESET = 2'b01,
        SRC_NMI   = 2'b10,
        SRC_IRQ   = 2'b11
    } source_t;

    localparam logic [1:0] PUSH_PCH = 2'b00;
    localparam logic [1:0] PUSH_PCL = 2'b01;
    localparam logic [1:0] PUSH_P   = 2'b10;

    localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;

    function automatic logic [15:0] vector_base(
        input source_t     src,
        input logic [15:0] nmi_vec,
        input logic [15:0] rst_vec,
        input logic [15:0] irq_vec
    );
        logic [15:0] base;
        case (src)
            SRC_RESET: base = rst_vec;
            SRC_NMI:   base = nmi_vec;
            default:   base = irq_vec;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pin/decoder inputs and datapath control outputs of the interrupt sequencer.
interface interrupt_sequencer_if;
    logic        i_nmi_n;
    logic        i_irq_n;
    logic        i_p_i;
    logic        i_instr_end;
    logic        i_brk;
    logic        o_busy;
    logic        o_force_brk;
    logic [2:0]  o_cycle;
    logic        o_push;
    logic [1:0]  o_push_sel;
    logic        o_write_inhibit;
    logic        o_b_flag;
    logic        o_set_i;
    logic        o_vec_fetch;
    logic [15:0] o_vec_addr;
    logic        o_done;
    logic [1:0]  o_source;

    modport master (
        input  i_nmi_n, i_irq_n, i_p_i, i_instr_end, i_brk,
        output o_busy, o_force_brk, o_cycle, o_push, o_push_sel, o_write_inhibit,
               o_b_flag, o_set_i, o_vec_fetch, o_vec_addr, o_done, o_source
    );

    modport slave (
        output i_nmi_n, i_irq_n, i_p_i, i_instr_end, i_brk,
        input  o_busy, o_force_brk, o_cycle, o_push, o_push_sel, o_write_inhibit,
               o_b_flag, o_set_i, o_vec_fetch, o_vec_addr, o_done, o_source
    );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI falling-edge latch: a new edge always wins over a same-cycle clear so
// that an NMI arriving while the previous one is being vectored is not lost.
module interrupt_sequencer_nmi_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ce,
    input  logic i_nmi_n,
    input  logic i_clear,
    output logic o_fall,
    output logic o_pending
);

    logic nmi_prev_r;
    logic nmi_pending_r;

    assign o_fall    = nmi_prev_r & ~i_nmi_n;
    assign o_pending = nmi_pending_r;

    // Previous pin level and pending flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            nmi_prev_r    <= 1'b1;
            nmi_pending_r <= 1'b0;
        end else if (i_ce) begin
            nmi_prev_r <= i_nmi_n;
            if (o_fall) begin
                nmi_pending_r <= 1'b1;
            end else if (i_clear) begin
                nmi_pending_r <= 1'b0;
            end else begin
                nmi_pending_r <= nmi_pending_r;
            end
        end else begin
            nmi_prev_r    <= nmi_prev_r;
            nmi_pending_r <= nmi_pending_r;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/BRK/reset entry sequencer: picks the source at an instruction
// boundary and runs the T1/PCH/PCL/P/VL/VH sequence with registered controls.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR,
    parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    interrupt_sequencer_if.master bus
);

    state_t      state_r, state_nxt_s;
    source_t     source_r, source_nxt_s;
    logic        brk_flag_r, brk_flag_nxt_s;
    logic        reset_pending_r, reset_pending_nxt_s;
    logic        force_nxt_s;
    logic        nmi_fall_s, nmi_pending_s, nmi_clear_s;
    logic        irq_ok_s, decide_s;

    logic        busy_r, force_brk_r, push_r, write_inhibit_r, b_flag_r;
    logic        set_i_r, vec_fetch_r, done_r;
    logic [1:0]  push_sel_r;
    logic [15:0] vec_addr_r;

    logic        push_nxt_s, write_inhibit_nxt_s, b_flag_nxt_s;
    logic        set_i_nxt_s, vec_fetch_nxt_s, done_nxt_s;
    logic [1:0]  push_sel_nxt_s;
    logic [15:0] vec_addr_nxt_s;

    interrupt_sequencer_nmi_edge_detect u_nmi (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ce      (i_ce),
        .i_nmi_n   (bus.i_nmi_n),
        .i_clear   (nmi_clear_s),
        .o_fall    (nmi_fall_s),
        .o_pending (nmi_pending_s)
    );

    assign irq_ok_s    = ~bus.i_irq_n & ~bus.i_p_i;
    assign decide_s    = bus.i_instr_end | bus.i_brk;
    // The NMI vector is fetched in VL only when the (possibly hijacked) source is NMI.
    assign nmi_clear_s = (state_r == S_VL) && (source_r == SRC_NMI);

    // Next-state, source latch and pending-reset bookkeeping.
    always_comb begin
        state_nxt_s         = state_r;
        source_nxt_s        = source_r;
        brk_flag_nxt_s      = brk_flag_r;
        reset_pending_nxt_s = reset_pending_r;
        force_nxt_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (decide_s && (reset_pending_r || nmi_pending_s || irq_ok_s)) begin
                    state_nxt_s    = S_T1;
                    force_nxt_s    = 1'b1;
                    brk_flag_nxt_s = 1'b0;
                    if (reset_pending_r) begin
                        source_nxt_s = SRC_RESET;
                    end else if (nmi_pending_s) begin
                        source_nxt_s = SRC_NMI;
                    end else begin
                        source_nxt_s = SRC_IRQ;
                    end
                end else if (bus.i_brk) begin
                    state_nxt_s    = S_T1;
                    source_nxt_s   = SRC_IRQ;
                    brk_flag_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_T1:  state_nxt_s = S_PCH;
            S_PCH: state_nxt_s = S_PCL;
            S_PCL: state_nxt_s = S_P;
            S_P: begin
                state_nxt_s = S_VL;
                // An NMI seen up to and including the P cycle steals the vector.
                if ((source_r == SRC_IRQ) && (nmi_pending_s || nmi_fall_s)) begin
                    source_nxt_s = SRC_NMI;
                end else begin
                    source_nxt_s = source_r;
                end
            end
            S_VL: begin
                state_nxt_s = S_VH;
                if (source_r == SRC_RESET) begin
                    reset_pending_nxt_s = 1'b0;
                end else begin
                    reset_pending_nxt_s = reset_pending_r;
                end
            end
            S_VH: begin
                state_nxt_s    = S_IDLE;
                source_nxt_s   = SRC_NONE;
                brk_flag_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s    = S_IDLE;
                source_nxt_s   = SRC_NONE;
                brk_flag_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath controls for the cycle being entered, registered below.
    always_comb begin
        push_nxt_s          = 1'b0;
        push_sel_nxt_s      = PUSH_PCH;
        write_inhibit_nxt_s = 1'b0;
        b_flag_nxt_s        = 1'b0;
        set_i_nxt_s         = 1'b0;
        vec_fetch_nxt_s     = 1'b0;
        vec_addr_nxt_s      = 16'h0000;
        done_nxt_s          = 1'b0;
        case (state_nxt_s)
            S_PCH: begin
                push_nxt_s          = 1'b1;
                push_sel_nxt_s      = PUSH_PCH;
                write_inhibit_nxt_s = (source_nxt_s == SRC_RESET);
            end
            S_PCL: begin
                push_nxt_s          = 1'b1;
                push_sel_nxt_s      = PUSH_PCL;
                write_inhibit_nxt_s = (source_nxt_s == SRC_RESET);
            end
            S_P: begin
                push_nxt_s          = 1'b1;
                push_sel_nxt_s      = PUSH_P;
                write_inhibit_nxt_s = (source_nxt_s == SRC_RESET);
                b_flag_nxt_s        = brk_flag_nxt_s;
            end
            S_VL: begin
                vec_fetch_nxt_s = 1'b1;
                set_i_nxt_s     = 1'b1;
                vec_addr_nxt_s  = vector_base(source_nxt_s, NMI_VECTOR, RESET_VECTOR, IRQ_VECTOR);
            end
            S_VH: begin
                vec_fetch_nxt_s = 1'b1;
                done_nxt_s      = 1'b1;
                vec_addr_nxt_s  = vector_base(source_nxt_s, NMI_VECTOR, RESET_VECTOR, IRQ_VECTOR) + 16'd1;
            end
            default: begin
                push_nxt_s = 1'b0;
            end
        endcase
    end

    // State, source and output registers; frozen while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r         <= S_IDLE;
            source_r        <= SRC_NONE;
            brk_flag_r      <= 1'b0;
            reset_pending_r <= 1'b1;
            busy_r          <= 1'b0;
            force_brk_r     <= 1'b0;
            push_r          <= 1'b0;
            push_sel_r      <= 2'b00;
            write_inhibit_r <= 1'b0;
            b_flag_r        <= 1'b0;
            set_i_r         <= 1'b0;
            vec_fetch_r     <= 1'b0;
            vec_addr_r      <= 16'h0000;
            done_r          <= 1'b0;
        end else if (i_ce) begin
            state_r         <= state_nxt_s;
            source_r        <= source_nxt_s;
            brk_flag_r      <= brk_flag_nxt_s;
            reset_pending_r <= reset_pending_nxt_s;
            busy_r          <= (state_nxt_s != S_IDLE);
            force_brk_r     <= force_nxt_s;
            push_r          <= push_nxt_s;
            push_sel_r      <= push_sel_nxt_s;
            write_inhibit_r <= write_inhibit_nxt_s;
            b_flag_r        <= b_flag_nxt_s;
            set_i_r         <= set_i_nxt_s;
            vec_fetch_r     <= vec_fetch_nxt_s;
            vec_addr_r      <= vec_addr_nxt_s;
            done_r          <= done_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign bus.o_busy          = busy_r;
    assign bus.o_force_brk     = force_brk_r;
    assign bus.o_cycle         = state_r;
    assign bus.o_push          = push_r;
    assign bus.o_push_sel      = push_sel_r;
    assign bus.o_write_inhibit = write_inhibit_r;
    assign bus.o_b_flag        = b_flag_r;
    assign bus.o_set_i         = set_i_r;
    assign bus.o_vec_fetch     = vec_fetch_r;
    assign bus.o_vec_addr      = vec_addr_r;
    assign bus.o_done          = done_r;
    assign bus.o_source        = source_r;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the 6502 interrupt/BRK/reset entry: prioritises sources, runs the 7-cycle stack-push and vector-fetch sequence, and drives the processor status register controls.
- Those controls are B value pushed with P and the set-I request.
- Sits in the CPU core between the pin synchronisers, the instruction decoder and the status/stack/address datapath.
- Pushes happen in normal time; reset-time pushes are inhibited.

Parameters:
- NMI_VECTOR, 16'hFFFA, NMI vector low-byte address
- RESET_VECTOR, 16'hFFFC, reset vector low-byte address
- IRQ_VECTOR, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_ce  in  1  clock enable; no state changes when low
- i_nmi_n  in  1  NMI pin, already synchronised, active low
- i_irq_n  in  1  IRQ pin, already synchronised, active low
- i_p_i  in  1  current I flag from status register
- i_instr_end  in  1  last cycle of current instruction (decision point)
- i_brk  in  1  decoder reports BRK opcode in its first execute cycle
- o_busy  out  1  sequence in progress
- o_force_brk  out  1  replace next fetched opcode with 8'h00, suppress PC increment
- o_cycle  out  3  state encoding (see Behaviour)
- o_push  out  1  stack write request this cycle
- o_push_sel  out  2  00 PCH, 01 PCL, 10 P
- o_write_inhibit  out  1  convert push into read (reset source)
- o_b_flag  out  1  value of bit 4 in the pushed P byte
- o_set_i  out  1  one-cycle request to set I in status register
- o_vec_fetch  out  1  vector read this cycle
- o_vec_addr  out  16  vector byte address (base, or base+1 in VH)
- o_done  out  1  one-cycle pulse on final cycle
- o_source  out  2  00 none, 01 RESET, 10 NMI, 11 IRQ/BRK

Behaviour:
- Clock and enable: all registers update on rising i_clk, only when i_ce=1; i_reset overrides i_ce.
- Reset values while i_reset=1: state IDLE, all outputs 0, o_vec_addr 0, nmi_pending 0, nmi_prev 1, reset_pending 1.
- NMI edge: nmi_prev<=i_nmi_n each enabled cycle. nmi_prev=1 & i_nmi_n=0 sets nmi_pending. nmi_pending clears on the VL cycle that fetches NMI_VECTOR. An edge during any state, including VL/VH, is retained.
- IRQ: level sensitive. Taken only if i_irq_n=0 & i_p_i=0 at the i_instr_end cycle; not latched.
- Decision, in IDLE with i_instr_end=1:
  - Priority is reset_pending > nmi_pending > irq.
  - If any is present: go to T1, o_force_brk=1 for that cycle, latch source.
  - i_brk=1 in IDLE with nothing pending: go to T1 with source IRQ/BRK, brk_flag=1, no force.
- States and cycles, one cycle each, strictly in order:
  - IDLE(0) -> T1(1) dummy read -> PCH(2) -> PCL(3) -> P(4) -> VL(5) -> VH(6) -> IDLE.
  - Take to o_done is 6 enabled cycles.
  - o_busy=1 in states 1-6.
- Push cycles (PCH, PCL, P):
  - o_push=1 with o_push_sel 00/01/10.
  - o_write_inhibit=1 when source=RESET.
  - o_b_flag=brk_flag in P only, 0 otherwise.
- VL: o_vec_fetch=1, o_set_i=1, o_vec_addr=selected base.
- VH: o_vec_fetch=1, o_vec_addr=base+1, o_done=1. reset_pending clears in VL of a RESET sequence.
- NMI hijack:
  - If nmi_pending is set by the P cycle (inclusive) of an IRQ/BRK sequence, VL/VH use NMI_VECTOR and nmi_pending clears.
  - o_b_flag keeps the original brk_flag.
  - o_source changes to NMI at VL.
  - An NMI arriving in VL/VH is not hijacked; it is serviced at the next boundary.
- Simultaneous events:
  - i_brk with pending IRQ: IRQ wins (forced BRK, brk_flag=0).
  - NMI edge on the same cycle as the decision is visible only next cycle; nmi_pending is sampled registered.
- i_ce=0 mid-sequence freezes state and outputs; nothing is skipped.
- i_reset mid-sequence: immediate return to reset values with reset_pending=1. The next boundary (i_instr_end) runs the RESET sequence.

Decomposition:
- Shared cpu6502 package holds:
  - state encodings (S_IDLE..S_VH)
  - source codes
  - push_sel codes
  - default vector constants
- Sub-module nmi_edge_detect: the nmi_prev/nmi_pending register with set on falling edge and clear input. Everything else is in one FSM.

Test Plan:
- Release reset, pulse i_instr_end:
  - cycles 1-6 show o_cycle 1..6.
  - o_push with o_write_inhibit=1 in 2-4.
  - o_vec_addr FFFC then FFFD.
  - o_set_i in cycle 5, o_done in 6.
  - A second boundary does not re-run reset.
- i_irq_n=0, i_p_i=0 at boundary:
  - o_force_brk=1.
  - P push has o_b_flag=0, no inhibit.
  - vectors FFFE/FFFF.
- i_irq_n=0 with i_p_i=1: no sequence. i_brk=1 instead: sequence with o_b_flag=1, vector FFFE.
- BRK taken, NMI falling edge during PCL:
  - o_b_flag=1 at P.
  - vectors FFFA/FFFB.
  - nmi_pending cleared.
  - no second NMI sequence.
- NMI edge in VH of an IRQ sequence: IRQ completes to FFFE/FFFF; next boundary runs NMI to FFFA. Holding i_nmi_n low afterwards causes no retrigger.
- i_reset asserted in PCH: outputs 0 next cycle. After release, a boundary gives a RESET sequence; i_ce low for 3 cycles mid-sequence stretches it with identical output values.
